nes_controller_port: RTL and testbench

- CPU-facing joypad register block for $4016/$4017, sitting between the two serial button receivers and the CPU data bus.
- Holds the latest button byte received for each pad.
- Implements the NES strobe/parallel-load and the 8-bit serial shift-out read protocol.
- Drives the shared CPU data bus only during its own read cycles.

---
 rtl/nes_ctrl_pkg.sv | 26 ++
 rtl/nes_controller_port_shifter.sv | 62 ++++++
 rtl/nes_controller_port.sv | 72 +++++++
 tb/tb_nes_controller_port.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nes_ctrl_pkg.sv
// Shared constants for the NES joypad register block ($4016/$4017).
package nes_ctrl_pkg;

    // Button bit positions within a received pad byte (1 = pressed)
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    // CPU address bit 0 selects the port
    localparam logic CTRL_ADDR_4016 = 1'b0;
    localparam logic CTRL_ADDR_4017 = 1'b1;

    // Upper bits seen on joypad reads (bit0 is replaced by the serial bit)
    localparam logic [7:0] NES_OPEN_BUS_DEFAULT = 8'h40;

    // Number of button bits shifted out before the line reads as 1
    localparam logic [3:0] SHIFT_LEN = 4'd8;

    typedef logic [7:0] btn_byte_t;

endpackage

// File: rtl/nes_controller_port_shifter.sv
module nes_pad_shifter
  import nes_ctrl_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT = 1789819
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic       rd_pulse,
  input  logic       rx_valid,
  input  btn_byte_t  rx_data,
  output logic       serial_bit
);

  btn_byte_t  buttons;
  btn_byte_t  shift;
  logic [3:0] cnt;

`ifdef CTRL_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(RX_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (rx_valid) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_W'(RX_TIMEOUT)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons <= '0;
      shift   <= '0;
      cnt     <= '0;
    end else begin
      if (rx_valid) begin
        buttons <= rx_data;
`ifdef CTRL_RX_TIMEOUT_EN
      end else if (to_cnt == TO_W'(RX_TIMEOUT)) begin
        buttons <= '0;
`endif
      end
      if (strobe) begin
        shift <= rx_valid ? rx_data : buttons;
        cnt   <= '0;
      end else if (rd_pulse && (cnt < SHIFT_LEN)) begin
        shift <= {1'b0, shift[7:1]};
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign serial_bit = (cnt == SHIFT_LEN) ? 1'b1 :
                      strobe             ? buttons[BTN_A] :
                                           shift[0];

endmodule

// File: rtl/nes_controller_port.sv
module nes_controller_port
  import nes_ctrl_pkg::*;
#(
  parameter int unsigned RX_TIMEOUT   = 1789819,
  parameter logic [7:0]  OPEN_BUS_VAL = NES_OPEN_BUS_DEFAULT
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       addr,
  input  logic       rw,
  inout  wire  [7:0] cpubus,
  input  logic       rx1_valid,
  input  logic [7:0] rx1_data,
  input  logic       rx2_valid,
  input  logic [7:0] rx2_data,
  output logic       strobe_out
);

  logic       strobe;
  logic [7:0] bus_in;
  logic       wr_4016;
  logic       rd_sel;
  logic       rd1;
  logic       rd2;
  logic       bit1;
  logic       bit2;
  logic       rd_bit;
  logic       unused_bus_bits;

  assign bus_in          = cpubus;
  assign unused_bus_bits = ^bus_in[7:1];

  assign wr_4016 = !cs && !rw && (addr == CTRL_ADDR_4016);
  assign rd_sel  = !cs && rw;
  assign rd1     = rd_sel && (addr == CTRL_ADDR_4016);
  assign rd2     = rd_sel && (addr == CTRL_ADDR_4017);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b0;
    end else if (wr_4016) begin
      strobe <= bus_in[0];
    end
  end

  nes_pad_shifter #(.RX_TIMEOUT(RX_TIMEOUT)) u_pad1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe     (strobe),
    .rd_pulse   (rd1),
    .rx_valid   (rx1_valid),
    .rx_data    (rx1_data),
    .serial_bit (bit1)
  );

  nes_pad_shifter #(.RX_TIMEOUT(RX_TIMEOUT)) u_pad2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe     (strobe),
    .rd_pulse   (rd2),
    .rx_valid   (rx2_valid),
    .rx_data    (rx2_data),
    .serial_bit (bit2)
  );

  assign rd_bit     = (addr == CTRL_ADDR_4017) ? bit2 : bit1;
  assign cpubus     = (rd_sel && rst_n) ? {OPEN_BUS_VAL[7:1], rd_bit} : 8'hzz;
  assign strobe_out = strobe;

endmodule

// File: tb/tb_nes_controller_port.sv
module tb_nes_controller_port;

  typedef struct {
    logic       cs;
    logic       rw;
    logic       addr;
    logic [7:0] wdata;
    logic       rx1v;
    logic [7:0] rx1d;
    logic       rx2v;
    logic [7:0] rx2d;
    logic       chk_bus;
    logic [7:0] exp_bus;
    logic       exp_strobe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic       addr = 1'b0;
  logic       rw = 1'b1;
  logic       rx1_valid = 1'b0;
  logic [7:0] rx1_data = 8'h00;
  logic       rx2_valid = 1'b0;
  logic [7:0] rx2_data = 8'h00;
  logic       strobe_out;
  logic       drv_en = 1'b0;
  logic [7:0] drv = 8'h00;
  wire  [7:0] cpubus;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  assign cpubus = drv_en ? drv : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (cpubus[g]);
  end

  always #5 clk = ~clk;

  nes_controller_port #(.RX_TIMEOUT(16), .OPEN_BUS_VAL(8'h40)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .addr       (addr),
    .rw         (rw),
    .cpubus     (cpubus),
    .rx1_valid  (rx1_valid),
    .rx1_data   (rx1_data),
    .rx2_valid  (rx2_valid),
    .rx2_data   (rx2_data),
    .strobe_out (strobe_out)
  );

  function automatic vec_t mk(logic c, logic r, logic a, logic [7:0] wd,
                              logic v1, logic [7:0] d1, logic v2, logic [7:0] d2,
                              logic cb, logic [7:0] eb, logic es);
    vec_t v;
    v.cs = c; v.rw = r; v.addr = a; v.wdata = wd;
    v.rx1v = v1; v.rx1d = d1; v.rx2v = v2; v.rx2d = d2;
    v.chk_bus = cb; v.exp_bus = eb; v.exp_strobe = es;
    return v;
  endfunction

  function automatic vec_t rd(logic a, logic [7:0] e, logic s);
    return mk(1'b0, 1'b1, a, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, e, s);
  endfunction

  function automatic vec_t wr(logic a, logic [7:0] d, logic s);
    return mk(1'b0, 1'b0, a, d, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, s);
  endfunction

  function automatic vec_t rx1(logic [7:0] d, logic s);
    return mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, d, 1'b0, 8'h00, 1'b1, 8'hFF, s);
  endfunction

  function automatic vec_t rx2(logic [7:0] d, logic s);
    return mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, d, 1'b1, 8'hFF, s);
  endfunction

  function automatic vec_t idle(logic s);
    return mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, s);
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    cs        = v.cs;
    rw        = v.rw;
    addr      = v.addr;
    drv       = v.wdata;
    drv_en    = !v.cs && !v.rw;
    rx1_valid = v.rx1v;
    rx1_data  = v.rx1d;
    rx2_valid = v.rx2v;
    rx2_data  = v.rx2d;
    @(negedge clk);
    if (v.chk_bus) check({tag, " bus"}, cpubus, v.exp_bus);
    check({tag, " strobe"}, {7'd0, strobe_out}, {7'd0, v.exp_strobe});
    @(posedge clk);
    #1;
    cs = 1'b1; rw = 1'b1; addr = 1'b0; drv_en = 1'b0;
    rx1_valid = 1'b0; rx2_valid = 1'b0;
  endtask

  initial begin
    #2;
    check("rst strobe_out", {7'd0, strobe_out}, 8'h00);
    check("rst bus idle", cpubus, 8'hFF);
    cs = 1'b0; rw = 1'b1;
    #2;
    check("rst bus read", cpubus, 8'hFF);
    cs = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    vecs.push_back(rx1(8'h09, 1'b0));
    vecs.push_back(wr(1'b0, 8'h01, 1'b0));
    vecs.push_back(wr(1'b0, 8'h00, 1'b1));
    vecs.push_back(rd(1'b0, 8'h41, 1'b0));
    vecs.push_back(rd(1'b0, 8'h40, 1'b0));
    vecs.push_back(rd(1'b0, 8'h40, 1'b0));
    vecs.push_back(rd(1'b0, 8'h41, 1'b0));
    vecs.push_back(rd(1'b0, 8'h40, 1'b0));
    vecs.push_back(rd(1'b0, 8'h40, 1'b0));
    vecs.push_back(rd(1'b0, 8'h40, 1'b0));
    vecs.push_back(rd(1'b0, 8'h40, 1'b0));
    vecs.push_back(rd(1'b0, 8'h41, 1'b0));
    vecs.push_back(rd(1'b0, 8'h41, 1'b0));
    vecs.push_back(wr(1'b0, 8'h01, 1'b0));
    vecs.push_back(rx1(8'h01, 1'b1));
    vecs.push_back(rd(1'b0, 8'h41, 1'b1));
    vecs.push_back(rd(1'b0, 8'h41, 1'b1));
    vecs.push_back(rd(1'b0, 8'h41, 1'b1));
    vecs.push_back(rx1(8'h00, 1'b1));
    vecs.push_back(rd(1'b0, 8'h40, 1'b1));
    vecs.push_back(rx2(8'h80, 1'b1));
    vecs.push_back(wr(1'b0, 8'h00, 1'b1));
    for (int unsigned k = 1; k <= 8; k++) begin
      vecs.push_back(rd(1'b0, 8'h40, 1'b0));
      vecs.push_back(rd(1'b1, (k == 8) ? 8'h41 : 8'h40, 1'b0));
    end
    vecs.push_back(rd(1'b1, 8'h41, 1'b0));
    vecs.push_back(rd(1'b0, 8'h41, 1'b0));
    vecs.push_back(wr(1'b1, 8'h01, 1'b0));
    vecs.push_back(idle(1'b0));
    vecs.push_back(wr(1'b0, 8'h01, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1));
    vecs.push_back(rd(1'b0, 8'h41, 1'b0));
    vecs.push_back(rd(1'b0, 8'h40, 1'b0));

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    apply(wr(1'b0, 8'h01, 1'b0), "mid wr1");
    apply(wr(1'b0, 8'h00, 1'b1), "mid wr0");
    apply(rd(1'b0, 8'h41, 1'b0), "mid rd1");
    apply(rd(1'b0, 8'h40, 1'b0), "mid rd2");
    apply(rd(1'b0, 8'h40, 1'b0), "mid rd3");
    apply(wr(1'b0, 8'h01, 1'b0), "mid wr1b");
    rst_n = 1'b0;
    cs = 1'b0; rw = 1'b1; addr = 1'b0;
    #2;
    check("midrst strobe_out", {7'd0, strobe_out}, 8'h00);
    check("midrst bus", cpubus, 8'hFF);
    cs = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(rd(1'b0, 8'h40, 1'b0), "post rst rd");

`ifdef CTRL_RX_TIMEOUT_EN
    apply(rx1(8'hFF, 1'b0), "to rx");
    for (int unsigned i = 0; i < 20; i++) apply(idle(1'b0), "to idle");
    apply(wr(1'b0, 8'h01, 1'b0), "to wr1");
    apply(wr(1'b0, 8'h00, 1'b1), "to wr0");
    apply(rd(1'b0, 8'h40, 1'b0), "to expired rd");
    apply(rx1(8'hFF, 1'b0), "to rx again");
    apply(wr(1'b0, 8'h01, 1'b0), "to wr1b");
    apply(wr(1'b0, 8'h00, 1'b1), "to wr0b");
    apply(rd(1'b0, 8'h41, 1'b0), "to restored rd");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
